// File: rtl/sh_divu.sv
// SH-2 DIVU: signed 64/32 and 32/32 divider with DVSR/DVCR/VCRDIV/DVDNTH/DVDNTL registers.
// Latency: DIV_CYCLES CE_R cycles from start write to result; bus accesses stall (IBUS_BUSY) while calculating.
module sh_divu #(
    parameter int DIV_CYCLES = 39
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic [4:0]  IBUS_A,
    input  logic        IBUS_SEL,
    input  logic [31:0] IBUS_DI,
    output logic [31:0] IBUS_DO,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT,
    output logic        IRQ,
    output logic [7:0]  IRQ_VEC,
    input  logic        IRQ_ACK
);

    typedef enum logic {IDLE, CALC} state_t;

    localparam logic [5:0] LAST_CNT = 6'(DIV_CYCLES - 1);

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] dvsr, dvdnth, dvdntl;
    logic [1:0]  dvcr;           // [1]=OVFIE, [0]=OVF
    logic [15:0] vcrdiv;
    logic [31:0] do_q;
    logic        irq_q;
    logic [31:0] rem, quo;

    logic        acc, wr, rd, start, last;
    logic [2:0]  reg_sel;
    logic [31:0] rd_mux;

    logic        a_neg, q_neg, ovf;
    logic [63:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] trial, diff;
    logic        ge;
    logic [31:0] rem_step, quo_step, q_res, r_res, q_sat;

    logic unused_inputs;
    assign unused_inputs = ^{IRQ_ACK, IBUS_A[1:0]};

    assign reg_sel   = IBUS_A[4:2];
    assign acc       = IBUS_SEL & IBUS_REQ & CE_R & (state == IDLE);
    assign IBUS_ACT  = acc;
    assign IBUS_BUSY = IBUS_SEL & IBUS_REQ & ~acc;
    assign wr        = acc & IBUS_WE;
    assign rd        = acc & ~IBUS_WE;
    assign start     = wr & ((reg_sel == 3'd1) | (reg_sel == 3'd5));
    assign last      = CE_R & (state == CALC) & (cnt == LAST_CNT);

    assign IBUS_DO = do_q;
    assign IRQ     = irq_q;
    assign IRQ_VEC = {1'b0, vcrdiv[6:0]};

    always_comb begin
        rd_mux = 32'h0;
        case (reg_sel)
            3'd0:    rd_mux = dvsr;
            3'd1:    rd_mux = dvdntl;
            3'd2:    rd_mux = {30'h0, dvcr};
            3'd3:    rd_mux = {16'h0, vcrdiv};
            3'd4:    rd_mux = dvdnth;
            3'd5:    rd_mux = dvdntl;
            3'd6:    rd_mux = dvdnth;
            default: rd_mux = dvdntl;
        endcase
    end

    // Operands stay stable through CALC because every bus access stalls there,
    // so the magnitudes are derived straight from the registers.
    always_comb begin
        a_neg = dvdnth[31];
        q_neg = dvdnth[31] ^ dvsr[31];
        a_mag = a_neg ? (64'h0 - {dvdnth, dvdntl}) : {dvdnth, dvdntl};
        b_mag = dvsr[31] ? (32'h0 - dvsr) : dvsr;

        trial    = {rem, quo[31]};
        diff     = trial - {1'b0, b_mag};
        ge       = (trial >= {1'b0, b_mag});
        rem_step = ge ? diff[31:0] : trial[31:0];
        quo_step = {quo[30:0], ge};

        // High half >= divisor means the quotient magnitude needs more than 32 bits.
        ovf = (b_mag == 32'h0) | (a_mag[63:32] >= b_mag) |
              (q_neg ? (quo > 32'h8000_0000) : quo[31]);

        q_res = q_neg ? (32'h0 - quo) : quo;
        r_res = a_neg ? (32'h0 - rem) : rem;
        q_sat = q_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= 6'd0;
            dvsr   <= 32'h0;
            dvdnth <= 32'h0;
            dvdntl <= 32'h0;
            dvcr   <= 2'b00;
            vcrdiv <= 16'h0;
            do_q   <= 32'h0;
            irq_q  <= 1'b0;
            rem    <= 32'h0;
            quo    <= 32'h0;
        end else if (CE_R) begin
            irq_q <= dvcr[0] & dvcr[1];
            if (rd) do_q <= rd_mux;
            if (wr) begin
                case (reg_sel)
                    3'd0: dvsr <= IBUS_DI;
                    3'd1: begin
                        dvdnth <= {32{IBUS_DI[31]}};
                        dvdntl <= IBUS_DI;
                    end
                    // OVF can only be cleared by software, never set.
                    3'd2: dvcr   <= {IBUS_DI[1], dvcr[0] & IBUS_DI[0]};
                    3'd3: vcrdiv <= IBUS_DI[15:0];
                    3'd4: dvdnth <= IBUS_DI;
                    3'd5: dvdntl <= IBUS_DI;
                    default: ;
                endcase
            end
            if (state == CALC) begin
                cnt <= cnt + 6'd1;
                if (cnt == 6'd0) begin
                    rem <= a_mag[63:32];
                    quo <= a_mag[31:0];
                end else if (cnt <= 6'd32) begin
                    rem <= rem_step;
                    quo <= quo_step;
                end
                if (cnt == LAST_CNT) begin
                    cnt <= 6'd0;
                    if (ovf) begin
                        dvcr[0] <= 1'b1;
                        dvdntl  <= q_sat;
                    end else begin
                        dvdntl <= q_res;
                        dvdnth <= r_res;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sh_divu.sv
// Self-checking bench for sh_divu: directed scenarios plus randomized divisions against a plain-arithmetic model.
module tb_sh_divu;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CE_R = 1'b1;
    logic [4:0]  IBUS_A = 5'h0;
    logic        IBUS_SEL = 1'b0;
    logic [31:0] IBUS_DI = 32'h0;
    logic [31:0] IBUS_DO;
    logic        IBUS_WE = 1'b0;
    logic        IBUS_REQ = 1'b0;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;
    logic        IRQ;
    logic [7:0]  IRQ_VEC;
    logic        IRQ_ACK = 1'b0;

    int checks = 0;
    int errors = 0;

    sh_divu #(.DIV_CYCLES(39)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R),
        .IBUS_A(IBUS_A), .IBUS_SEL(IBUS_SEL), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO),
        .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
        .IRQ(IRQ), .IRQ_VEC(IRQ_VEC), .IRQ_ACK(IRQ_ACK)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // One bus access; returns read data and number of stalled cycles. Starts and ends just after a posedge.
    task automatic bus(input logic we, input logic [4:0] a, input logic [31:0] d,
                       output logic [31:0] rdat, output int stalls);
        bit ok;
        ok = 0;
        stalls = 0;
        IBUS_SEL = 1'b1; IBUS_REQ = 1'b1; IBUS_WE = we; IBUS_A = a; IBUS_DI = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (IBUS_ACT === 1'b1) begin
                ok = 1;
                break;
            end
            stalls++;
        end
        @(posedge CLK);
        #1;
        rdat = IBUS_DO;
        IBUS_SEL = 1'b0; IBUS_REQ = 1'b0; IBUS_WE = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bus_timeout addr=%h: no IBUS_ACT within 200 cycles", a);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        int st;
        bus(1'b1, a, d, dummy, st);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] q);
        int st;
        bus(1'b0, a, 32'h0, q, st);
    endtask

    // Reference: signed division on 64-bit integers, saturating per the overflow rules.
    function automatic void ref_div(input logic [31:0] h, input logic [31:0] l, input logic [31:0] s,
                                    output logic [31:0] nh, output logic [31:0] nl, output bit ov);
        longint dd, ds, q, r;
        dd = longint'($signed({h, l}));
        ds = longint'($signed(s));
        q = 0; r = 0;
        if (ds == 0 || (ds == -1 && dd == 64'sh8000_0000_0000_0000)) ov = 1;
        else begin
            q = dd / ds;
            r = dd % ds;
            ov = (q > 64'sd2147483647) || (q < -64'sd2147483648);
        end
        if (ov) begin
            nh = h;
            nl = ((dd < 0) != (ds < 0)) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            nh = r[31:0];
            nl = q[31:0];
        end
    endfunction

    task automatic test_reset();
        logic [31:0] q;
        #12;
        checks++; if (IBUS_DO !== 32'h0)  begin errors++; $display("FAIL rst_do got=%h exp=0", IBUS_DO); end
        checks++; if (IBUS_BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", IBUS_BUSY); end
        checks++; if (IBUS_ACT !== 1'b0)  begin errors++; $display("FAIL rst_act got=%b exp=0", IBUS_ACT); end
        checks++; if (IRQ !== 1'b0)       begin errors++; $display("FAIL rst_irq got=%b exp=0", IRQ); end
        checks++; if (IRQ_VEC !== 8'h0)   begin errors++; $display("FAIL rst_vec got=%h exp=0", IRQ_VEC); end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) begin
            rd(5'(i * 4), q);
            checks++;
            if (q !== 32'h0) begin errors++; $display("FAIL rst_reg addr=%h got=%h exp=0", i * 4, q); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] q;
        int st;
        wr(5'h00, 32'd7);
        wr(5'h04, 32'd100);
        bus(1'b0, 5'h14, 32'h0, q, st);
        checks++; if (st != 39) begin errors++; $display("FAIL stall_count got=%0d exp=39", st); end
        checks++; if (q !== 32'd14) begin errors++; $display("FAIL pos_quot got=%h exp=%h", q, 32'd14); end
        rd(5'h10, q);
        checks++; if (q !== 32'd2) begin errors++; $display("FAIL pos_rem got=%h exp=2", q); end
        rd(5'h04, q);
        checks++; if (q !== 32'd14) begin errors++; $display("FAIL dvdnt_read got=%h exp=%h", q, 32'd14); end
        rd(5'h08, q);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL pos_dvcr got=%h exp=0", q); end
        wr(5'h04, 32'hFFFF_FF9C);
        rd(5'h1C, q);
        checks++; if (q !== 32'hFFFF_FFF2) begin errors++; $display("FAIL neg_quot got=%h exp=fffffff2", q); end
        rd(5'h18, q);
        checks++; if (q !== 32'hFFFF_FFFE) begin errors++; $display("FAIL neg_rem got=%h exp=fffffffe", q); end
    endtask

    task automatic test_64();
        logic [31:0] q;
        wr(5'h10, 32'd1);
        wr(5'h00, 32'd4);
        wr(5'h14, 32'd0);
        rd(5'h14, q);
        checks++; if (q !== 32'h4000_0000) begin errors++; $display("FAIL div64_quot got=%h exp=40000000", q); end
        rd(5'h10, q);
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL div64_rem got=%h exp=0", q); end
    endtask

    task automatic test_overflow_irq();
        logic [31:0] q;
        wr(5'h08, 32'd2);
        wr(5'h0C, 32'h45);
        wr(5'h10, 32'd1);
        wr(5'h00, 32'd1);
        wr(5'h14, 32'd0);
        rd(5'h14, q);
        checks++; if (q !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ovf_sat got=%h exp=7fffffff", q); end
        rd(5'h10, q);
        checks++; if (q !== 32'h1) begin errors++; $display("FAIL ovf_keep_h got=%h exp=1", q); end
        rd(5'h08, q);
        checks++; if (q !== 32'h3) begin errors++; $display("FAIL ovf_flag got=%h exp=3", q); end
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", IRQ); end
        checks++; if (IRQ_VEC !== 8'h45) begin errors++; $display("FAIL irq_vec got=%h exp=45", IRQ_VEC); end
        wr(5'h08, 32'd3);
        rd(5'h08, q);
        checks++; if (q !== 32'h3) begin errors++; $display("FAIL ovf_w1_noeffect got=%h exp=3", q); end
        wr(5'h08, 32'd2);
        checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_lag got=%b exp=1", IRQ); end
        @(posedge CLK);
        #1;
        checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", IRQ); end
        rd(5'h08, q);
        checks++; if (q !== 32'h2) begin errors++; $display("FAIL ovf_clear got=%h exp=2", q); end
        wr(5'h0C, 32'hFFFF_FFFF);
        rd(5'h0C, q);
        checks++; if (q !== 32'h0000_FFFF) begin errors++; $display("FAIL vcr_mask got=%h exp=ffff", q); end
        checks++; if (IRQ_VEC !== 8'h7F) begin errors++; $display("FAIL vec_mask got=%h exp=7f", IRQ_VEC); end
        wr(5'h08, 32'hFFFF_FFFF);
        rd(5'h08, q);
        checks++; if (q !== 32'h2) begin errors++; $display("FAIL dvcr_mask got=%h exp=2", q); end
        wr(5'h08, 32'h0);
    endtask

    task automatic test_div_zero();
        logic [31:0] q;
        wr(5'h00, 32'h0);
        wr(5'h04, 32'hFFFF_FFFB);
        rd(5'h14, q);
        checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL dz_neg got=%h exp=80000000", q); end
        rd(5'h10, q);
        checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_keep_h got=%h exp=ffffffff", q); end
        rd(5'h08, q);
        checks++; if (q !== 32'h1) begin errors++; $display("FAIL dz_ovf got=%h exp=1", q); end
        wr(5'h08, 32'h0);
        wr(5'h04, 32'd5);
        rd(5'h14, q);
        checks++; if (q !== 32'h7FFF_FFFF) begin errors++; $display("FAIL dz_pos got=%h exp=7fffffff", q); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        wr(5'h00, 32'd3);
        wr(5'h04, 32'd1000);
        IBUS_SEL = 1'b1; IBUS_REQ = 1'b1; IBUS_WE = 1'b0; IBUS_A = 5'h14;
        repeat (20) @(posedge CLK);
        #1;
        checks++; if (IBUS_BUSY !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", IBUS_BUSY); end
        RST_N = 1'b0;
        #1;
        checks++; if (IBUS_BUSY !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", IBUS_BUSY); end
        IBUS_SEL = 1'b0; IBUS_REQ = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 6; i++) begin
            rd(5'(i * 4), q);
            checks++;
            if (q !== 32'h0) begin errors++; $display("FAIL mid_rst_reg addr=%h got=%h exp=0", i * 4, q); end
        end
        wr(5'h00, 32'd3);
        wr(5'h04, 32'd1000);
        rd(5'h14, q);
        checks++; if (q !== 32'd333) begin errors++; $display("FAIL post_rst_quot got=%h exp=%h", q, 32'd333); end
        rd(5'h10, q);
        checks++; if (q !== 32'd1) begin errors++; $display("FAIL post_rst_rem got=%h exp=1", q); end
    endtask

    task automatic test_random();
        logic [31:0] s, h, l, eh, el, q;
        bit ov, m_ovf;
        m_ovf = 0;
        wr(5'h08, 32'h0);
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                wr(5'h08, 32'h0);
                m_ovf = 0;
            end
            case ($urandom_range(0, 5))
                0:       s = 32'h0;
                1:       s = $urandom_range(0, 1) ? 32'h1 : 32'hFFFF_FFFF;
                2:       s = $urandom_range(0, 1) ? 32'($urandom_range(1, 15)) : 32'h0 - 32'($urandom_range(1, 15));
                default: s = $urandom;
            endcase
            l = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            wr(5'h00, s);
            if ($urandom_range(0, 1) == 0) begin
                h = {32{l[31]}};
                wr(5'h04, l);
            end else begin
                case ($urandom_range(0, 3))
                    0:       h = 32'h0;
                    1:       h = 32'hFFFF_FFFF;
                    2:       h = 32'($urandom_range(0, 7));
                    default: h = $urandom;
                endcase
                wr(5'h10, h);
                wr(5'h14, l);
            end
            ref_div(h, l, s, eh, el, ov);
            m_ovf = m_ovf | ov;
            rd($urandom_range(0, 1) ? 5'h14 : 5'h1C, q);
            checks++;
            if (q !== el) begin errors++; $display("FAIL rnd_l it=%0d h=%h l=%h s=%h got=%h exp=%h", it, h, l, s, q, el); end
            rd($urandom_range(0, 1) ? 5'h10 : 5'h18, q);
            checks++;
            if (q !== eh) begin errors++; $display("FAIL rnd_h it=%0d h=%h l=%h s=%h got=%h exp=%h", it, h, l, s, q, eh); end
            rd(5'h08, q);
            checks++;
            if (q !== {31'h0, m_ovf}) begin errors++; $display("FAIL rnd_ovf it=%0d got=%h exp=%h", it, q, {31'h0, m_ovf}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_64();
        test_overflow_irq();
        test_div_zero();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sh_divu.md
Name: sh_divu

Overview:
- Signed division unit of the SH-2 on-chip peripheral set (DIVU). It sits on the internal peripheral bus next to the INTC.
- Holds the DVSR, DVCR, VCRDIV, DVDNTH and DVDNTL registers.
- A write to DVDNT (32/32) or DVDNTL (64/32) starts a fixed 39-cycle signed division.
- On overflow it raises an interrupt request; the INTC consumes this request together with the IPRA.DIVUIP level.

Parameters:
- DIV_CYCLES, 39, CE_R cycles from start write to result registers updated.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CE_R  in  1  clock enable; all state advances only when CE_R=1.
- IBUS_A  in  5  byte address offset within FFFFFF00-FFFFFF3F; bits [1:0] ignored.
- IBUS_SEL  in  1  decoded select for the DIVU window.
- IBUS_DI  in  32  write data.
- IBUS_DO  out  32  read data.
- IBUS_WE  in  1  1=write, 0=read.
- IBUS_REQ  in  1  access strobe.
- IBUS_BUSY  out  1  stall: access not accepted this cycle.
- IBUS_ACT  out  1  access accepted this cycle.
- IRQ  out  1  overflow interrupt request.
- IRQ_VEC  out  8  interrupt vector, {1'b0, VCRDIV[6:0]}.
- IRQ_ACK  in  1  INTC acknowledge; no state change, kept for interface uniformity.

Behaviour:
- Address map, offsets 0x20-0x3F alias 0x00-0x1F:
  - 0x00 DVSR
  - 0x04 DVDNT (write: 32/32 start)
  - 0x08 DVCR
  - 0x0C VCRDIV
  - 0x10 DVDNTH
  - 0x14 DVDNTL (write: 64/32 start)
  - 0x18 reads DVDNTH (alias)
  - 0x1C reads DVDNTL (alias)
- Reading 0x04 returns DVDNTL.
- All accesses are treated as longword.
- Write masks: DVCR 0x00000003, VCRDIV 0x0000FFFF. Masked bits read 0.
- Reset values: all registers 0. IBUS_DO=0, IBUS_BUSY=0, IBUS_ACT=0, IRQ=0, IRQ_VEC=0, FSM=IDLE.
- FSM IDLE -> CALC -> IDLE:
  - IDLE: an accepted write to 0x04 sets DVDNTH = sign-extend(IBUS_DI), DVDNTL = IBUS_DI, then -> CALC. An accepted write to 0x14 sets DVDNTL only (DVDNTH was written before), then -> CALC.
  - CALC: cycle counter runs 1..DIV_CYCLES (CE_R cycles after the start write). On count DIV_CYCLES, write the results and return to IDLE.
- Results, normal case: DVDNTL = quotient truncated toward zero; DVDNTH = remainder, with the sign of the dividend. The dividend is the 64-bit value {DVDNTH, DVDNTL}.
- Overflow occurs when DVSR == 0, or when the true quotient lies outside [-2^31, 2^31-1].
  - DVCR.OVF is set.
  - DVDNTL saturates to 0x7FFFFFFF if the quotient sign is positive, else 0x80000000. Quotient sign = sign(dividend) XOR sign(DVSR); for DVSR == 0 it is the dividend sign.
  - DVDNTH keeps its pre-division value.
  - OVF is set on the same CE_R edge as the result write.
- OVF clears only when software writes 0 to it. Writing 1 to OVF has no effect; hardware never clears it.
- IRQ = DVCR.OVF & DVCR.OVFIE, registered, one cycle after the bits change. IRQ_VEC tracks VCRDIV combinationally.
- Bus handshake:
  - Every access (read or write, any register) with IBUS_SEL & IBUS_REQ during CALC gives IBUS_BUSY=1 and IBUS_ACT=0.
  - A stalled access is accepted on the first IDLE cycle, i.e. the cycle after the result write.
  - In IDLE, accesses are accepted in the same cycle: IBUS_ACT=1, and IBUS_DO is valid in that cycle (registered output, updated on CE_R).
- A start write while another start is pending cannot occur, because all accesses stall in CALC.
- RST_N assertion mid-CALC aborts the division and clears all registers immediately.

Test Plan:
- DVSR=7, write DVDNT=100 -> reads stall 39 cycles, then DVDNTL=14, DVDNTH=2, OVF=0.
- DVSR=7, write DVDNT=0xFFFFFF9C (-100) -> DVDNTL=0xFFFFFFF2 (-14), DVDNTH=0xFFFFFFFE (-2).
- DVDNTH=1, DVSR=4, write DVDNTL=0 -> DVDNTL=0x40000000, DVDNTH=0.
- DVCR=2 (OVFIE), VCRDIV=0x45, DVDNTH=1, DVSR=1, write DVDNTL=0:
  - DVDNTL=0x7FFFFFFF, DVDNTH=1, OVF=1.
  - IRQ=1 with IRQ_VEC=0x45.
  - Writing DVCR=2 clears OVF, and IRQ drops next cycle.
- DVSR=0, write DVDNT=0xFFFFFFFB -> OVF=1, DVDNTL=0x80000000. With DVDNT=5 instead -> DVDNTL=0x7FFFFFFF.
- Pull RST_N low at cycle 20 of a division -> all registers read 0, IBUS_BUSY=0; a new division after reset completes normally.
